// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types, width helpers and error-bit indices for the result collector
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_SHORT    = 1;

    // Product of two DATA_WIDTH operands accumulated into one element
    function automatic int result_width(input int dw);
        return 2 * dw;
    endfunction

    // Index width for n entries, never narrower than one bit
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_result_ram.sv
// rtl/matrix_result_ram.sv - 1W/1R buffer with registered, read-before-write read port
module matrix_result_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage and read register; non-blocking update gives the old word on a same-address collision
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/matrix_result_collector.sv
// rtl/matrix_result_collector.sv - captures a row-major M x P result stream and serves it by address
module matrix_result_collector
    import matrix_pkg::*;
#(
    parameter  int M          = 2,
    parameter  int P          = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int DONE_GRACE = 4,
    localparam int RW         = result_width(DATA_WIDTH),
    localparam int MP         = M * P,
    localparam int CW         = index_width(MP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic [RW-1:0] c_in,
    input  logic          c_valid,
    input  logic          mm_done,
    input  logic          rd_en,
    input  logic [CW-1:0] rd_addr,
    output logic [RW-1:0] rd_data,
    output logic          rd_valid,
    output logic [CW:0]   count,
    output logic          row_done,
    output logic          busy,
    output logic          full,
    output logic [1:0]    err
);

    localparam int PW = index_width(P);
    localparam int GW = index_width(DONE_GRACE + 1);
    localparam logic [CW:0]   LAST_IDX    = (CW + 1)'(MP - 1);
    localparam logic [PW-1:0] LAST_COL    = PW'(P - 1);
    localparam logic [GW-1:0] GRACE_LIMIT = GW'(DONE_GRACE);

    state_e        state_q, state_d;
    logic [CW:0]   count_q, count_d;
    logic [PW-1:0] col_q, col_d;
    logic [1:0]    err_q, err_d;
    logic          full_q, full_d;
    logic          row_done_q, row_done_d;
    logic [GW-1:0] grace_q, grace_d;
    logic [GW-1:0] grace_next;
    logic          mm_done_q;
    logic          mm_rise;
    logic          wr_en;
    logic          rd_in_range;
    logic          rd_ok_q;
    logic          rd_valid_q;
    logic [RW-1:0] ram_rd_data;

    assign mm_rise     = mm_done & ~mm_done_q;
    assign grace_next  = grace_q + 1'b1;
    assign rd_in_range = ({1'b0, rd_addr} <= LAST_IDX);

    // Capture sequencing: arm restarts everything, beats fill the buffer, grace window bounds a short stream
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        col_d      = col_q;
        err_d      = err_q;
        full_d     = full_q;
        grace_d    = grace_q;
        row_done_d = 1'b0;
        wr_en      = 1'b0;
        if (arm) begin
            state_d = ST_CAPTURE;
            count_d = '0;
            col_d   = '0;
            err_d   = '0;
            full_d  = 1'b0;
            grace_d = '0;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (c_valid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d      = '0;
                            row_done_d = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                    if (c_valid && (count_q == LAST_IDX)) begin
                        state_d = ST_COMPLETE;
                        full_d  = 1'b1;
                        grace_d = '0;
                    end else if ((grace_q != '0) || mm_rise) begin
                        // The mm_done rising-edge cycle counts as the first grace cycle
                        if (grace_next == GRACE_LIMIT) begin
                            err_d[ERR_SHORT] = 1'b1;
                            state_d          = ST_COMPLETE;
                            full_d           = 1'b0;
                            grace_d          = '0;
                        end else begin
                            grace_d = grace_next;
                        end
                    end
                end
                ST_COMPLETE: begin
                    if (c_valid) begin
                        err_d[ERR_OVERFLOW] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters, flags and read-side qualifiers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            col_q      <= '0;
            err_q      <= '0;
            full_q     <= 1'b0;
            row_done_q <= 1'b0;
            grace_q    <= '0;
            mm_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            col_q      <= col_d;
            err_q      <= err_d;
            full_q     <= full_d;
            row_done_q <= row_done_d;
            grace_q    <= grace_d;
            mm_done_q  <= mm_done;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_ok_q <= rd_in_range;
            end
        end
    end

    matrix_result_ram #(
        .DEPTH (MP),
        .WIDTH (RW),
        .AW    (CW)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (count_q[CW-1:0]),
        .wr_data_i (c_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_in_range ? rd_addr : '0),
        .rd_data_o (ram_rd_data)
    );

    assign rd_data  = rd_ok_q ? ram_rd_data : '0;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign row_done = row_done_q;
    assign busy     = (state_q == ST_CAPTURE);
    assign full     = full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_matrix_result_collector.sv
// tb/tb_matrix_result_collector.sv - randomized self-checking bench against a buffer-level reference model
module tb_matrix_result_collector;

    localparam int M  = 2;
    localparam int P  = 4;
    localparam int RW = 16;
    localparam int MP = 8;
    localparam int CW = 3;
    localparam int BCW = 4;
    localparam int BMP = 9;

    logic          clk = 1'b0;
    logic          rst_n, arm, c_valid, mm_done, rd_en;
    logic [RW-1:0] c_in;
    logic [CW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic          rd_valid, row_done, busy, full;
    logic [CW:0]   count;
    logic [1:0]    err;

    logic           b_arm, b_c_valid, b_mm_done, b_rd_en;
    logic [RW-1:0]  b_c_in, b_rd_data;
    logic [BCW-1:0] b_rd_addr;
    logic           b_rd_valid, b_row_done, b_busy, b_full;
    logic [BCW:0]   b_count;
    logic [1:0]     b_err;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] model_mem [MP];
    bit            model_known [MP];
    int            model_count;
    bit            model_cap;
    int            pulses;

    logic [RW-1:0] happy [MP] = '{16'd3, 16'd9, 16'd2, 16'd1, 16'd6, 16'd21, 16'd2, 16'd7};

    always #5 clk = ~clk;

    matrix_result_collector #(.M(M), .P(P), .DATA_WIDTH(8), .DONE_GRACE(4)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .c_in(c_in), .c_valid(c_valid),
        .mm_done(mm_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .row_done(row_done), .busy(busy),
        .full(full), .err(err)
    );

    matrix_result_collector #(.M(3), .P(3), .DATA_WIDTH(8), .DONE_GRACE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .arm(b_arm), .c_in(b_c_in), .c_valid(b_c_valid),
        .mm_done(b_mm_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .count(b_count), .row_done(b_row_done), .busy(b_busy),
        .full(b_full), .err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        model_count = 0;
        model_cap   = 1'b1;
    endtask

    task automatic beat(input logic [RW-1:0] v);
        c_valid = 1'b1;
        c_in    = v;
        tick();
        c_valid = 1'b0;
        if (model_cap) begin
            model_mem[model_count]   = v;
            model_known[model_count] = 1'b1;
            model_count++;
            if (model_count == MP) model_cap = 1'b0;
        end
    endtask

    task automatic rd(input logic [CW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; c_valid = 1'b0; c_in = '0; mm_done = 1'b0; rd_en = 1'b0; rd_addr = '0;
        b_arm = 1'b0; b_c_valid = 1'b0; b_c_in = '0; b_mm_done = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0;
        model_count = 0; model_cap = 1'b0;
        for (int i = 0; i < MP; i++) model_known[i] = 1'b0;
        tick(); tick();
        checks++; if (count !== 4'd0)   begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (busy !== 1'b0 || full !== 1'b0 || row_done !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b full=%b row_done=%b expected 0 0 0", busy, full, row_done); end
        checks++; if (err !== 2'b00)    begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL reset_rd: got valid=%b data=%h expected 0 0000", rd_valid, rd_data); end
        rst_n = 1'b1;
        tick();
        c_valid = 1'b1; c_in = 16'h1234; tick(); c_valid = 1'b0;
        checks++; if (count !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ignores_beat: got count=%0d busy=%b expected 0 0", count, busy); end
    endtask

    task automatic test_happy();
        do_arm();
        checks++; if (busy !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL arm_busy: got busy=%b count=%0d expected 1 0", busy, count); end
        for (int i = 0; i < MP; i++) begin
            if (i == 6) mm_done = 1'b1;
            beat(happy[i]);
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL happy_count: got %0d expected 8", count); end
        checks++; if (full !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL happy_full: got full=%b busy=%b expected 1 0", full, busy); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL happy_err: got %b expected 00", err); end
        rd(3'd5);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'd21) begin errors++; $display("FAIL happy_rd5: got valid=%b data=%0d expected 1 21", rd_valid, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 16'd21) begin errors++; $display("FAIL rd_hold: got valid=%b data=%0d expected 0 21", rd_valid, rd_data); end
        mm_done = 1'b0;
        tick();
    endtask

    task automatic test_negative();
        logic [RW-1:0] v;
        do_arm();
        pulses = 0;
        for (int i = 0; i < MP; i++) begin
            v = (i == 2) ? 16'hFFFB : RW'($urandom);
            beat(v);
            if (row_done) pulses++;
            checks++; if (row_done !== ((i % P) == P - 1)) begin errors++; $display("FAIL row_done_beat%0d: got %b expected %b", i, row_done, (i % P) == P - 1); end
        end
        tick();
        checks++; if (row_done !== 1'b0) begin errors++; $display("FAIL row_done_after: got %b expected 0", row_done); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL row_done_pulses: got %0d expected 2", pulses); end
        for (int i = 0; i < MP; i++) begin
            rd(CW'(i));
            checks++; if (rd_data !== model_mem[i]) begin errors++; $display("FAIL neg_rd%0d: got %h expected %h", i, rd_data, model_mem[i]); end
        end
    endtask

    task automatic test_short();
        do_arm();
        for (int i = 0; i < 6; i++) beat(RW'($urandom));
        mm_done = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (err !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL short_early_%0d: got err=%b busy=%b expected 00 1", k, err, busy); end
        end
        tick();
        model_cap = 1'b0;
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL short_err: got %b expected 10", err); end
        checks++; if (full !== 1'b0 || busy !== 1'b0 || count !== 4'd6) begin errors++; $display("FAIL short_state: got full=%b busy=%b count=%0d expected 0 0 6", full, busy, count); end
        mm_done = 1'b0;
        rd(3'd4);
        checks++; if (rd_data !== model_mem[4]) begin errors++; $display("FAIL short_rd4: got %h expected %h", rd_data, model_mem[4]); end
    endtask

    task automatic test_overflow();
        do_arm();
        for (int i = 0; i < MP; i++) beat(happy[i]);
        beat(16'd99);
        checks++; if (err !== 2'b01 || count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL overflow_flags: got err=%b count=%0d full=%b expected 01 8 1", err, count, full); end
        rd(3'd0);
        checks++; if (rd_data !== 16'd3) begin errors++; $display("FAIL overflow_buf0: got %0d expected 3", rd_data); end
        tick();
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL err_sticky: got %b expected 01", err); end
    endtask

    task automatic test_rearm();
        do_arm();
        checks++; if (err !== 2'b00 || count !== 4'd0 || busy !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rearm: got err=%b count=%0d busy=%b full=%b expected 00 0 1 0", err, count, busy, full); end
        arm = 1'b1; c_valid = 1'b1; c_in = 16'd55;
        tick();
        arm = 1'b0; c_valid = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL arm_collision: got count=%0d expected 0", count); end
        rd_en = 1'b1; rd_addr = 3'd0;
        beat(16'd88);
        rd_en = 1'b0;
        checks++; if (rd_data !== 16'd3) begin errors++; $display("FAIL read_before_write: got %0d expected 3", rd_data); end
        rd(3'd0);
        checks++; if (rd_data !== 16'd88 || count !== 4'd1) begin errors++; $display("FAIL after_write: got data=%0d count=%0d expected 88 1", rd_data, count); end
    endtask

    task automatic test_random();
        logic [RW-1:0] exp_rd;
        bit            exp_known;
        bit            v;
        int            cyc;
        do_arm();
        cyc = 0;
        while (model_count < MP && cyc < 300) begin
            v       = $urandom_range(0, 1) == 1;
            c_valid = v;
            c_in    = RW'($urandom);
            rd_en   = $urandom_range(0, 2) != 0;
            rd_addr = CW'($urandom);
            exp_known = rd_en && model_known[rd_addr];
            exp_rd    = model_mem[rd_addr];
            tick();
            if (v) begin
                model_mem[model_count]   = c_in;
                model_known[model_count] = 1'b1;
                model_count++;
            end
            checks++; if (rd_valid !== rd_en || count !== (CW + 1)'(model_count)) begin errors++; $display("FAIL rand_cycle%0d: got valid=%b count=%0d expected %b %0d", cyc, rd_valid, count, rd_en, model_count); end
            if (exp_known) begin
                checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rand_rd%0d: got %h expected %h", cyc, rd_data, exp_rd); end
            end
            cyc++;
        end
        c_valid = 1'b0; rd_en = 1'b0;
        model_cap = 1'b0;
        checks++; if (model_count != MP || full !== 1'b1) begin errors++; $display("FAIL rand_complete: got beats=%0d full=%b expected 8 1", model_count, full); end
        for (int i = 0; i < MP; i++) begin
            rd(CW'(i));
            checks++; if (rd_data !== model_mem[i]) begin errors++; $display("FAIL rand_final%0d: got %h expected %h", i, rd_data, model_mem[i]); end
        end
    endtask

    task automatic test_range();
        logic [RW-1:0] last;
        b_arm = 1'b1; tick(); b_arm = 1'b0;
        for (int i = 0; i < BMP; i++) begin
            b_c_valid = 1'b1; b_c_in = RW'(i * 7 + 5); last = b_c_in;
            tick();
        end
        b_c_valid = 1'b0;
        checks++; if (b_full !== 1'b1 || b_count !== 5'd9) begin errors++; $display("FAIL range_capture: got full=%b count=%0d expected 1 9", b_full, b_count); end
        b_rd_en = 1'b1; b_rd_addr = 4'd8; tick(); b_rd_en = 1'b0;
        checks++; if (b_rd_data !== last) begin errors++; $display("FAIL range_last: got %0d expected %0d", b_rd_data, last); end
        for (int a = BMP; a < 16; a++) begin
            b_rd_en = 1'b1; b_rd_addr = BCW'(a); tick(); b_rd_en = 1'b0;
            checks++; if (b_rd_data !== '0 || b_rd_valid !== 1'b1) begin errors++; $display("FAIL range_oob%0d: got data=%h valid=%b expected 0000 1", a, b_rd_data, b_rd_valid); end
        end
    endtask

    task automatic test_reset_mid();
        do_arm();
        for (int i = 0; i < 3; i++) beat(RW'($urandom));
        rd(3'd1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || busy !== 1'b0 || full !== 1'b0 || err !== 2'b00) begin errors++; $display("FAIL midreset_state: got count=%0d busy=%b full=%b err=%b expected 0 0 0 00", count, busy, full, err); end
        checks++; if (rd_data !== '0 || rd_valid !== 1'b0 || row_done !== 1'b0) begin errors++; $display("FAIL midreset_rd: got data=%h valid=%b row_done=%b expected 0000 0 0", rd_data, rd_valid, row_done); end
        tick();
        rst_n = 1'b1;
        model_cap = 1'b0;
        tick();
        beat(16'd11); beat(16'd12);
        checks++; if (count !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_ignore: got count=%0d busy=%b expected 0 0", count, busy); end
        do_arm();
        beat(16'd13);
        checks++; if (count !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL midreset_rearm: got count=%0d busy=%b expected 1 1", count, busy); end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_negative();
        test_short();
        test_overflow();
        test_rearm();
        test_random();
        test_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
